// File: rtl/sha3_msg_packer.sv
// sha3_msg_packer: packs 1..4-byte little-endian message beats into 32-bit
// KMAC message FIFO writes with byte strobes and a final-word marker.
module sha3_msg_packer #(
  parameter int unsigned                ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0]      MSG_FIFO_ADDR = 32'h0000_1800
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic [2:0]            in_nbytes,
  input  logic                  in_last,
  output logic                  out_dv,
  input  logic                  out_hld,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_write,
  output logic [31:0]           out_wdata,
  output logic [3:0]            out_wstrb,
  output logic [2:0]            out_size,
  output logic                  out_last,
  output logic                  busy_o,
  output logic                  err_o
);
  typedef enum logic {ACC, FLUSH} state_t;
  state_t      r_state;
  logic [31:0] r_acc, r_wdata;
  logic [1:0]  r_cnt, w_pn;
  logic [3:0]  r_wstrb, w_total, w_pstrb;
  logic [2:0]  r_size, w_psize;
  logic        r_dv, r_last, r_err;
  logic        w_free, w_fire, w_legal;
  logic [31:0] w_dmask, w_mdata, w_merge, w_rem;
  assign w_free   = !r_dv || !out_hld;
  assign in_ready = reset_n && (r_state == ACC) && w_free;
  assign w_fire   = in_valid && in_ready;
  assign w_legal  = (in_nbytes != 3'd0) && (in_nbytes <= 3'd4);
  assign w_dmask  = {{8{in_nbytes >= 3'd4}}, {8{in_nbytes >= 3'd3}},
                     {8{in_nbytes >= 3'd2}}, {8{in_nbytes >= 3'd1}}};
  assign w_mdata  = in_data & w_dmask;
  assign w_total  = {2'b00, r_cnt} + {1'b0, in_nbytes};
  assign w_merge  = r_acc | (w_mdata << {r_cnt, 3'b000});
  // bytes that spill past the current word; a shift of 32 yields zero when cnt is 0
  assign w_rem    = w_mdata >> {3'd4 - {1'b0, r_cnt}, 3'b000};
  assign w_pn     = (r_state == FLUSH) ? r_cnt : w_total[1:0];
  assign w_pstrb  = (4'd1 << w_pn) - 4'd1;
  assign w_psize  = (w_pn == 2'd1) ? 3'd0 : (w_pn == 2'd2) ? 3'd1 : 3'd2;
  assign out_addr  = MSG_FIFO_ADDR;
  assign out_write = 1'b1;
  assign out_dv    = r_dv;
  assign out_wdata = r_wdata;
  assign out_wstrb = r_wstrb;
  assign out_size  = r_size;
  assign out_last  = r_last;
  assign err_o     = r_err;
  assign busy_o    = (r_cnt != 2'd0) || r_dv || (r_state == FLUSH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dv    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_size  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_dv && !out_hld) r_dv <= 1'b0;
      if (r_state == FLUSH) begin
        if (w_free) begin
          r_dv    <= 1'b1;
          r_wdata <= r_acc;
          r_wstrb <= w_pstrb;
          r_size  <= w_psize;
          r_last  <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= ACC;
        end
      end else if (w_fire) begin
        if (!w_legal) begin
          r_err <= 1'b1;
        end else if (w_total >= 4'd4) begin
          r_dv    <= 1'b1;
          r_wdata <= w_merge;
          r_wstrb <= 4'hf;
          r_size  <= 3'd2;
          r_last  <= in_last && (w_total == 4'd4);
          r_acc   <= w_rem;
          r_cnt   <= w_total[1:0];
          if (in_last && (w_total != 4'd4)) r_state <= FLUSH;
        end else if (in_last) begin
          r_dv    <= 1'b1;
          r_wdata <= w_merge;
          r_wstrb <= w_pstrb;
          r_size  <= w_psize;
          r_last  <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_merge;
          r_cnt <= w_total[1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_sha3_msg_packer.sv
// tb_sha3_msg_packer: directed scenario tasks with hand-computed words,
// completed transfers collected by a monitor and compared per scenario.
module tb_sha3_msg_packer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_hld = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_nbytes = '0;
  logic        in_ready, out_dv, out_write, out_last, busy_o, err_o;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_wstrb;
  logic [2:0]  out_size;
  int          total_n = 0, bad_n = 0, cyc = 0;
  typedef struct {logic [31:0] d; logic [3:0] s; logic [2:0] z; logic l; int c;} wr_t;
  wr_t q[$];

  sha3_msg_packer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .out_dv(out_dv), .out_hld(out_hld), .out_addr(out_addr), .out_write(out_write),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_size(out_size),
    .out_last(out_last), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (reset_n && out_dv && !out_hld) q.push_back('{out_wdata, out_wstrb, out_size, out_last, cyc});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required <20000", cyc);
    $fatal(1);
  end

  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic l);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_nbytes = n; in_last = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1 ok = in_ready;
      @(negedge clk);
    end
    total_n++;
    if (!ok) begin
      bad_n++;
      $display("FAIL send_accept: beat %h/%0d not accepted, in_ready=%b required 1", d, n, in_ready);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_nbytes = '0;
  endtask

  task automatic drain();
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    total_n++;
    if ({in_ready, out_dv, out_wdata, out_wstrb, out_size, out_last, err_o, busy_o} !== '0) begin
      bad_n++;
      $display("FAIL reset_outputs: rdy=%b dv=%b wd=%h st=%h sz=%0d last=%b err=%b busy=%b required all 0",
               in_ready, out_dv, out_wdata, out_wstrb, out_size, out_last, err_o, busy_o);
    end
    total_n++;
    if (out_addr !== 32'h0000_1800 || out_write !== 1'b1) begin
      bad_n++;
      $display("FAIL const_outputs: addr=%h write=%b required 00001800 1", out_addr, out_write);
    end
    reset_n = 1'b1;
    #1 total_n++;
    if (in_ready !== 1'b1 || busy_o !== 1'b0) begin
      bad_n++;
      $display("FAIL reset_release: rdy=%b busy=%b required 1 0", in_ready, busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_full_beats();
    logic [31:0] exp_d [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    q.delete();
    for (int i = 0; i < 4; i++) send(exp_d[i], 3'd4, i == 3);
    drain();
    total_n++;
    if (q.size() != 4) begin
      bad_n++;
      $display("FAIL full_count: words=%0d required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total_n++;
      if (q[i].d !== exp_d[i] || q[i].s !== 4'hf || q[i].z !== 3'd2 || q[i].l !== (i == 3) ||
          q[i].c !== q[0].c + i) begin
        bad_n++;
        $display("FAIL full_word%0d: d=%h s=%h z=%0d l=%b c=%0d required %h f 2 %b c=%0d",
                 i, q[i].d, q[i].s, q[i].z, q[i].l, q[i].c, exp_d[i], i == 3, q[0].c + i);
      end
    end
  endtask

  task automatic test_single_bytes();
    q.delete();
    send(32'hFFFFFFAA, 3'd1, 1'b0);
    send(32'h123456BB, 3'd1, 1'b0);
    send(32'h0000FFCC, 3'd1, 1'b0);
    send(32'hABCDEFDD, 3'd1, 1'b1);
    drain();
    total_n++;
    if (q.size() != 1 || q[0].d !== 32'hDDCCBBAA || q[0].s !== 4'hf || q[0].z !== 3'd2 || q[0].l !== 1'b1) begin
      bad_n++;
      $display("FAIL single_bytes: n=%0d d=%h s=%h z=%0d l=%b required 1 DDCCBBAA f 2 1",
               q.size(), q.size() ? q[0].d : 0, q.size() ? q[0].s : 0, q.size() ? q[0].z : 0, q.size() ? q[0].l : 0);
    end
  endtask

  task automatic test_flush();
    q.delete();
    send(32'h00332211, 3'd3, 1'b0);
    send(32'h00665544, 3'd3, 1'b1);
    idle();
    #1 total_n++;
    if (in_ready !== 1'b0 || busy_o !== 1'b1 || out_dv !== 1'b1) begin
      bad_n++;
      $display("FAIL flush_ready: rdy=%b busy=%b dv=%b required 0 1 1", in_ready, busy_o, out_dv);
    end
    drain();
    total_n++;
    if (q.size() != 2) begin
      bad_n++;
      $display("FAIL flush_count: words=%0d required 2", q.size());
    end else begin
      total_n++;
      if (q[0].d !== 32'h44332211 || q[0].s !== 4'hf || q[0].z !== 3'd2 || q[0].l !== 1'b0) begin
        bad_n++;
        $display("FAIL flush_word0: d=%h s=%h z=%0d l=%b required 44332211 f 2 0", q[0].d, q[0].s, q[0].z, q[0].l);
      end
      total_n++;
      if (q[1].d !== 32'h00006655 || q[1].s !== 4'h3 || q[1].z !== 3'd1 || q[1].l !== 1'b1 || q[1].c !== q[0].c + 1) begin
        bad_n++;
        $display("FAIL flush_word1: d=%h s=%h z=%0d l=%b required 00006655 3 1 1", q[1].d, q[1].s, q[1].z, q[1].l);
      end
    end
  endtask

  task automatic test_hold();
    q.delete();
    send(32'hCAFEF00D, 3'd4, 1'b0);
    out_hld = 1'b1;
    in_valid = 1'b1; in_data = 32'h12345678; in_nbytes = 3'd4; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 total_n++;
      if (out_dv !== 1'b1 || out_wdata !== 32'hCAFEF00D || out_wstrb !== 4'hf || in_ready !== 1'b0) begin
        bad_n++;
        $display("FAIL hold_cycle%0d: dv=%b wd=%h st=%h rdy=%b required 1 CAFEF00D f 0",
                 i, out_dv, out_wdata, out_wstrb, in_ready);
      end
      @(negedge clk);
    end
    out_hld = 1'b0;
    send(32'h12345678, 3'd4, 1'b1);
    drain();
    total_n++;
    if (q.size() != 2 || q[0].d !== 32'hCAFEF00D || q[0].l !== 1'b0 || q[1].d !== 32'h12345678 || q[1].l !== 1'b1) begin
      bad_n++;
      $display("FAIL hold_words: n=%0d d0=%h d1=%h required 2 CAFEF00D 12345678",
               q.size(), q.size() > 0 ? q[0].d : 0, q.size() > 1 ? q[1].d : 0);
    end
  endtask

  task automatic test_err();
    q.delete();
    send(32'h00000011, 3'd1, 1'b0);
    send(32'h00000099, 3'd0, 1'b0);
    #1 total_n++;
    if (err_o !== 1'b1) begin
      bad_n++;
      $display("FAIL err_pulse_n0: err=%b required 1", err_o);
    end
    send(32'hEEEEEEEE, 3'd7, 1'b1);
    #1 total_n++;
    if (err_o !== 1'b1 || out_dv !== 1'b0 || busy_o !== 1'b1) begin
      bad_n++;
      $display("FAIL err_pulse_n7: err=%b dv=%b busy=%b required 1 0 1", err_o, out_dv, busy_o);
    end
    send(32'h00443322, 3'd3, 1'b1);
    #1 total_n++;
    if (err_o !== 1'b0) begin
      bad_n++;
      $display("FAIL err_clear: err=%b required 0", err_o);
    end
    drain();
    total_n++;
    if (q.size() != 1 || q[0].d !== 32'h44332211 || q[0].s !== 4'hf || q[0].l !== 1'b1) begin
      bad_n++;
      $display("FAIL err_word: n=%0d d=%h required 1 44332211", q.size(), q.size() ? q[0].d : 0);
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    send(32'h0000BBAA, 3'd2, 1'b0);
    send(32'h11223344, 3'd4, 1'b0);
    out_hld = 1'b1;
    idle();
    #1 total_n++;
    if (out_dv !== 1'b1 || out_wdata !== 32'h3344BBAA || busy_o !== 1'b1) begin
      bad_n++;
      $display("FAIL mid_pre: dv=%b wd=%h busy=%b required 1 3344BBAA 1", out_dv, out_wdata, busy_o);
    end
    #2 reset_n = 1'b0;
    #1 total_n++;
    if ({in_ready, out_dv, out_wdata, out_wstrb, out_size, out_last, err_o, busy_o} !== '0) begin
      bad_n++;
      $display("FAIL mid_reset: rdy=%b dv=%b wd=%h st=%h sz=%0d last=%b busy=%b required all 0",
               in_ready, out_dv, out_wdata, out_wstrb, out_size, out_last, busy_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_hld = 1'b0;
    #1 total_n++;
    if (in_ready !== 1'b1 || busy_o !== 1'b0) begin
      bad_n++;
      $display("FAIL mid_release: rdy=%b busy=%b required 1 0", in_ready, busy_o);
    end
    @(negedge clk);
    send(32'h55667788, 3'd4, 1'b1);
    drain();
    total_n++;
    if (q.size() != 1 || q[0].d !== 32'h55667788 || q[0].s !== 4'hf || q[0].l !== 1'b1) begin
      bad_n++;
      $display("FAIL mid_after: n=%0d d=%h required 1 55667788", q.size(), q.size() ? q[0].d : 0);
    end
  endtask

  initial begin
    test_reset();
    test_full_beats();
    test_single_bytes();
    test_flush();
    test_hold();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/sha3_msg_packer.md
SHA3_MSG_PACKER -- requirements
Module: sha3_msg_packer

Interface
REQ-001 SHALL have parameter MSG_FIFO_ADDR, default 32'h0000_1800, meaning the AHB-side address of the KMAC message FIFO, driven on out_addr.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the width of out_addr.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  message beat present.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 in_data  input  32  message bytes, little-endian, valid in the low in_nbytes bytes.
REQ-008 in_nbytes  input  3  count of valid bytes; legal values are 1..4.
REQ-009 in_last  input  1  final beat of the message.
REQ-010 out_dv  output  1  valid-hold request to the TLUL adapter.
REQ-011 out_hld  input  1  adapter stall; a transfer completes in a cycle with out_dv=1 and out_hld=0.
REQ-012 out_addr  output  ADDR_WIDTH  constant MSG_FIFO_ADDR.
REQ-013 out_write  output  1  constant 1.
REQ-014 out_wdata  output  32  packed word.
REQ-015 out_wstrb  output  4  byte strobes.
REQ-016 out_size  output  3  2 when out_wstrb=4'b1111 or 4'b0111; 1 when 4'b0011; 0 when 4'b0001.
REQ-017 out_last  output  1  word carries the final message byte.
REQ-018 busy_o  output  1  high when the accumulator is non-empty, out_dv=1, or the state is FLUSH.
REQ-019 err_o  output  1  one-cycle pulse on an illegal beat.

Function
REQ-020 SHALL keep a 32-bit accumulator acc, a byte count cnt in 0..3, and a one-entry output register (out_dv, out_wdata, out_wstrb, out_size, out_last).
REQ-021 SHALL hold the output payload stable while out_dv=1 and out_hld=1; out_dv SHALL deassert the cycle after completion unless a new word is loaded in the same cycle.
REQ-022 in_ready SHALL equal (state==ACC) && (!out_dv || !out_hld), which gives zero-bubble back-to-back words.
REQ-023 On an accepted beat with legal in_nbytes, SHALL set total = cnt + in_nbytes (4-bit arithmetic).
REQ-024 If total>=4, SHALL load word = (acc | in_data<<(8*cnt))[31:0] with wstrb 1111, set acc = in_data>>(8*(4-cnt)), and set cnt = total-4.
REQ-025 If total<4 and in_last=0, SHALL merge the bytes into acc, set cnt=total, and load no output.
REQ-026 If total<4 and in_last=1, SHALL load the partial word with wstrb=(1<<total)-1 and out_last=1, then set cnt=0 and acc=0.
REQ-027 If total==4 and in_last=1, SHALL set out_last=1 on the full word and clear cnt.
REQ-028 If total>4 and in_last=1, SHALL load the full word with out_last=0, enter FLUSH, and hold the leftover (cnt=total-4) in acc.
REQ-029 In FLUSH, once the previous word completes, SHALL load the leftover with wstrb=(1<<cnt)-1 and out_last=1, clear acc/cnt, and return to ACC; in_ready SHALL be 0 throughout FLUSH.
REQ-030 States: ACC (reset) and FLUSH only.
REQ-031 For in_nbytes of 0 or 5..7, SHALL drop the beat (it counts as accepted), pulse err_o for one cycle, and leave acc, cnt, state and the output register unchanged.
REQ-032 Unused high bytes of in_data SHALL be ignored (masked before merge); acc bytes at and above cnt SHALL always be zero.

Reset
REQ-033 On reset_n=0, asynchronously: in_ready=0, out_dv=0, out_wdata=0, out_wstrb=0, out_size=0, out_last=0, err_o=0, busy_o=0, acc=0, cnt=0, state=ACC.
REQ-034 Reset mid-message or mid-hold SHALL discard all buffered bytes without emitting any partial word; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-035 Four 4-byte beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, last on the fourth, out_hld=0 -> four consecutive words, wstrb 1111, out_last only on 0x0F0E0D0C, no bubbles.
REQ-036 Beats nbytes 1,1,1,1 with data 0xAA, 0xBB, 0xCC, 0xDD (last) -> single word 0xDDCCBBAA, wstrb 1111, size 2, out_last=1.
REQ-037 Beats nbytes 3 (0x00332211) then 3 (0x00665544, last) -> word 0x44332211 out_last=0, then FLUSH word 0x00006655, wstrb 0011, size 1, out_last=1; in_ready=0 during FLUSH.
REQ-038 out_hld held high for 5 cycles with out_dv=1 -> payload stable, in_ready=0, no beat lost; a beat arriving later is accepted once out_hld falls.
REQ-039 in_nbytes=0 mid-stream -> err_o pulses for 1 cycle and packed output is identical to a run without that beat.
REQ-040 reset_n asserted with cnt=2 and out_dv=1 -> all outputs 0 immediately; the next message packs from byte lane 0.
